// File: rtl/fft_twiddle_sequencer_if.sv
// Stream bundle for fft_twiddle_sequencer.
//
// Three channels share this interface:
//   recv_* : sine-table samples into the sequencer (msg, val, rdy)
//   req_*  : stage/inverse requests into the sequencer (stage, inverse, val, rdy)
//   send_* : twiddle stream out of the sequencer (msg, idx, last, val, rdy)
//
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where val and rdy are both high. A producer holding val high keeps its
// payload stable until that transfer. The sequencer never lowers send_val
// before its handshake.
//
// Modports: master = the environment that feeds samples and requests and
// drains twiddles; slave = the sequencer itself.
interface fft_twiddle_sequencer_if #(
  parameter int BIT_WIDTH = 16,
  parameter int SIZE_FFT  = 8
);
  localparam int LOG2N   = $clog2(SIZE_FFT);
  localparam int STAGE_W = ($clog2(LOG2N) < 1) ? 1 : $clog2(LOG2N);
  localparam int IDX_W   = $clog2(SIZE_FFT / 2);

  logic [BIT_WIDTH-1:0]   recv_msg;
  logic                   recv_val;
  logic                   recv_rdy;

  logic [STAGE_W-1:0]     req_stage;
  logic                   req_inverse;
  logic                   req_val;
  logic                   req_rdy;

  logic [2*BIT_WIDTH-1:0] send_msg;
  logic [IDX_W-1:0]       send_idx;
  logic                   send_last;
  logic                   send_val;
  logic                   send_rdy;

  modport master (
    output recv_msg, recv_val,
    input  recv_rdy,
    output req_stage, req_inverse, req_val,
    input  req_rdy,
    input  send_msg, send_idx, send_last, send_val,
    output send_rdy
  );

  modport slave (
    input  recv_msg, recv_val,
    output recv_rdy,
    input  req_stage, req_inverse, req_val,
    output req_rdy,
    output send_msg, send_idx, send_last, send_val,
    input  send_rdy
  );
endinterface

// File: rtl/fft_twiddle_sequencer.sv
// Stage-programmable twiddle-factor source for a Cooley-Tukey FFT.
//
// A one-period sine table (entry n = sin(2*pi*n/SIZE_FFT)) is loaded over
// the recv channel into a local register file. Each accepted request then
// streams the SIZE_FFT/2 twiddles of the selected stage on the send channel,
// one per handshake, optionally conjugated for the inverse transform.
//
// Ports:
//   clk       : clock
//   reset     : asynchronous active-low reset; aborts to LOAD
//   bus       : fft_twiddle_sequencer_if.slave (recv / req / send channels)
//   dbg_state : current FSM state (0 = LOAD, 1 = IDLE, 2 = STREAM)
//
// Twiddle for butterfly p at stage s:
//   idx  = (p mod 2^s) * SIZE_FFT / 2^(s+1)
//   real = entry[(idx + SIZE_FFT/4) mod SIZE_FFT]   (cosine by quarter shift)
//   imag = -entry[idx] (forward) or +entry[idx] (inverse), saturating
module fft_twiddle_sequencer #(
  parameter int BIT_WIDTH  = 16,
  parameter int DECIMAL_PT = 8,
  parameter int SIZE_FFT   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  fft_twiddle_sequencer_if.slave        bus,
  output logic [1:0]                    dbg_state
);

  localparam int LOG2N   = $clog2(SIZE_FFT);
  localparam int ADDR_W  = LOG2N;
  localparam int IDX_W   = $clog2(SIZE_FFT / 2);
  localparam int STAGE_W = ($clog2(LOG2N) < 1) ? 1 : $clog2(LOG2N);

  localparam logic [ADDR_W-1:0]    LAST_ENTRY = ADDR_W'(SIZE_FFT - 1);
  localparam logic [IDX_W-1:0]     LAST_P     = IDX_W'(SIZE_FFT / 2 - 1);
  localparam logic [ADDR_W-1:0]    QUARTER    = ADDR_W'(SIZE_FFT / 4);
  localparam logic [STAGE_W-1:0]   TOP_STAGE  = STAGE_W'(LOG2N - 1);
  localparam logic [BIT_WIDTH-1:0] SMIN       = {1'b1, {(BIT_WIDTH-1){1'b0}}};
  localparam logic [BIT_WIDTH-1:0] SMAX       = ~SMIN;

  // The fraction position does not change any index or sign logic; it only
  // has to leave room for the sign bit.
  if (SIZE_FFT < 4 || (1 << LOG2N) != SIZE_FFT || DECIMAL_PT >= BIT_WIDTH) begin : g_bad_params
    $error("fft_twiddle_sequencer: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_IDLE   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     count_q;
  logic [STAGE_W-1:0]    stage_q;
  logic                  inv_q;
  logic [BIT_WIDTH-1:0]  table_q [SIZE_FFT];

  logic                  load_acc, req_acc, send_hs;
  logic [ADDR_W-1:0]     wr_addr;
  logic [STAGE_W-1:0]    req_stage_c;
  logic [IDX_W-1:0]      p_next;

  logic [IDX_W-1:0]      tw_p;
  logic [STAGE_W-1:0]    tw_s;
  logic                  tw_inv;
  logic [ADDR_W-1:0]     tw_mask, tw_shamt, tw_idx, tw_re_addr;
  logic [BIT_WIDTH-1:0]  tw_re, tw_im_raw, tw_im_neg, tw_im;

  assign dbg_state = state_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    bus.recv_rdy = 1'b0;
    bus.req_rdy  = 1'b0;
    case (state_q)
      S_LOAD: begin
        bus.recv_rdy = 1'b1;
        if (bus.recv_val && count_q == LAST_ENTRY) state_d = S_IDLE;
      end
      S_IDLE: begin
        bus.req_rdy  = 1'b1;
        // A pending request wins over a reload sample.
        bus.recv_rdy = !bus.req_val;
        if (bus.req_val)       state_d = S_STREAM;
        else if (bus.recv_val) state_d = S_LOAD;
      end
      S_STREAM: begin
        if (bus.send_val && bus.send_rdy && bus.send_last) state_d = S_IDLE;
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign load_acc = bus.recv_val && bus.recv_rdy;
  assign req_acc  = bus.req_val && bus.req_rdy;
  assign send_hs  = bus.send_val && bus.send_rdy;

  // A sample taken in IDLE is the start of a reload, so it lands in entry 0.
  assign wr_addr  = (state_q == S_IDLE) ? '0 : count_q;

  assign req_stage_c = (32'(bus.req_stage) >= LOG2N) ? TOP_STAGE : bus.req_stage;
  assign p_next      = bus.send_idx + IDX_W'(1);

  // ---------------------------------------------------- twiddle lookup
  // In IDLE the lookup serves the incoming request (p = 0); in STREAM it
  // prepares the entry after the one on the bus so a handshake can replace
  // it without a bubble.
  always_comb begin
    tw_p   = p_next;
    tw_s   = stage_q;
    tw_inv = inv_q;
    if (state_q == S_IDLE) begin
      tw_p   = '0;
      tw_s   = req_stage_c;
      tw_inv = bus.req_inverse;
    end
    // m = p & (2^s - 1); idx = m << (log2N - 1 - s). Since m < 2^s the
    // result stays below SIZE_FFT/2.
    tw_mask    = (ADDR_W'(1) << tw_s) - ADDR_W'(1);
    tw_shamt   = ADDR_W'(LOG2N - 1) - ADDR_W'(tw_s);
    tw_idx     = (ADDR_W'(tw_p) & tw_mask) << tw_shamt;
    tw_re_addr = tw_idx + QUARTER;
    tw_re      = table_q[tw_re_addr];
    tw_im_raw  = table_q[tw_idx];
    // The most negative code has no positive twin; clip it to the maximum.
    tw_im_neg  = (tw_im_raw == SMIN) ? SMAX : (~tw_im_raw + 1'b1);
    tw_im      = tw_inv ? tw_im_raw : tw_im_neg;
  end

  // ------------------------------------------------------- table storage
  // Contents are meaningless until a full load, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (load_acc) table_q[wr_addr] <= bus.recv_msg;
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q       <= '0;
      stage_q       <= '0;
      inv_q         <= 1'b0;
      bus.send_val  <= 1'b0;
      bus.send_msg  <= '0;
      bus.send_idx  <= '0;
      bus.send_last <= 1'b0;
    end else begin
      if (load_acc) count_q <= wr_addr + ADDR_W'(1);

      if (req_acc) begin
        stage_q       <= req_stage_c;
        inv_q         <= bus.req_inverse;
        bus.send_val  <= 1'b1;
        bus.send_msg  <= {tw_re, tw_im};
        bus.send_idx  <= '0;
        bus.send_last <= (LAST_P == '0);
      end else if (send_hs) begin
        if (bus.send_last) begin
          bus.send_val <= 1'b0;
        end else begin
          bus.send_msg  <= {tw_re, tw_im};
          bus.send_idx  <= p_next;
          bus.send_last <= (p_next == LAST_P);
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Directed bench for fft_twiddle_sequencer with SIZE_FFT=8, BIT_WIDTH=16.
module tb_fft_twiddle_sequencer;

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         checks;
  int         errors;

  fft_twiddle_sequencer_if #(.BIT_WIDTH(16), .SIZE_FFT(8)) bus ();

  fft_twiddle_sequencer #(
    .BIT_WIDTH(16),
    .DECIMAL_PT(8),
    .SIZE_FFT(8)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // ------------------------------------------------ clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // sin table scaled by 256: [0,181,256,181,0,-181,-256,-181]
  logic [15:0] tbl_a [8] = '{16'h0000, 16'h00B5, 16'h0100, 16'h00B5,
                             16'h0000, 16'hFF4B, 16'hFF00, 16'hFF4B};
  // same table with entry 2 forced to the most negative code
  logic [15:0] tbl_b [8] = '{16'h0000, 16'h00B5, 16'h8000, 16'h00B5,
                             16'h0000, 16'hFF4B, 16'hFF00, 16'hFF4B};

  // expected {real, imag} per butterfly p
  logic [31:0] exp_s0     [4] = '{32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000};
  logic [31:0] exp_s1     [4] = '{32'h0100_0000, 32'h0000_FF00, 32'h0100_0000, 32'h0000_FF00};
  logic [31:0] exp_s2     [4] = '{32'h0100_0000, 32'h00B5_FF4B, 32'h0000_FF00, 32'hFF4B_FF4B};
  logic [31:0] exp_s2_inv [4] = '{32'h0100_0000, 32'h00B5_00B5, 32'h0000_0100, 32'hFF4B_00B5};
  logic [31:0] exp_b_s1   [4] = '{32'h8000_0000, 32'h0000_7FFF, 32'h8000_0000, 32'h0000_7FFF};
  logic [31:0] exp_b_s2   [4] = '{32'h8000_0000, 32'h00B5_FF4B, 32'h0000_7FFF, 32'hFF4B_FF4B};

  // ------------------------------------------------------- driver tasks
  task automatic load_table(input logic [15:0] vals [8]);
    int w;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.recv_msg = vals[i];
      bus.recv_val = 1'b1;
      #1;
      w = 0;
      while (bus.recv_rdy !== 1'b1 && w < 20) begin
        @(negedge clk);
        #1;
        w++;
      end
      if (bus.recv_rdy !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL load_timeout sample %0d: recv_rdy=%b, required 1", i, bus.recv_rdy);
      end
      if (i > 0) begin
        checks++;
        if (bus.req_rdy !== 1'b0) begin
          errors++;
          $display("FAIL load_req_rdy sample %0d: req_rdy=%b, required 0", i, bus.req_rdy);
        end
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus.recv_val = 1'b0;
    #1;
    checks++;
    if (dbg_state !== ST_IDLE || bus.req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL load_done: state=%0d req_rdy=%b, required state=%0d req_rdy=1",
               dbg_state, bus.req_rdy, ST_IDLE);
    end
  endtask

  // Issues one request and checks the first twiddle is valid one cycle later.
  task automatic request(input logic [1:0] s, input logic inv);
    int w;
    @(negedge clk);
    bus.req_stage   = s;
    bus.req_inverse = inv;
    bus.req_val     = 1'b1;
    #1;
    w = 0;
    while (bus.req_rdy !== 1'b1 && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    @(posedge clk);
    #1;
    bus.req_val = 1'b0;
    checks++;
    if (bus.send_val !== 1'b1 || dbg_state !== ST_STREAM) begin
      errors++;
      $display("FAIL req_latency s=%0d: send_val=%b state=%0d, required send_val=1 state=%0d",
               s, bus.send_val, dbg_state, ST_STREAM);
    end
  endtask

  // Drains one stage; every cycle the bus must show expected entry k.
  task automatic collect(input string name, input logic [31:0] exp_msg [4], input bit rnd);
    int k;
    int budget;
    k = 0;
    budget = 0;
    while (k < 4 && budget < 200) begin
      @(negedge clk);
      bus.send_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      budget++;
      checks++;
      if (bus.send_val !== 1'b1) begin
        errors++;
        $display("FAIL %s p=%0d: send_val=%b, required 1", name, k, bus.send_val);
        break;
      end
      if (bus.send_msg !== exp_msg[k] || bus.send_idx !== k[1:0] || bus.send_last !== (k == 3)) begin
        errors++;
        $display("FAIL %s p=%0d: msg=%h idx=%0d last=%b, required msg=%h idx=%0d last=%b",
                 name, k, bus.send_msg, bus.send_idx, bus.send_last, exp_msg[k], k, (k == 3));
      end
      if (bus.send_rdy) k++;
    end
    if (k < 4 && budget >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d twiddles, required 4", name, k);
    end
    @(negedge clk);
    bus.send_rdy = 1'b0;
    #1;
    checks++;
    if (bus.send_val !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL %s end: send_val=%b state=%0d, required send_val=0 state=%0d",
               name, bus.send_val, dbg_state, ST_IDLE);
    end
  endtask

  // ------------------------------------------------------------- tests
  task automatic test_reset();
    bus.recv_msg    = '0;
    bus.recv_val    = 1'b0;
    bus.req_stage   = '0;
    bus.req_inverse = 1'b0;
    bus.req_val     = 1'b0;
    bus.send_rdy    = 1'b0;
    rst_n           = 1'b0;
    #12;
    checks++;
    if (bus.send_val !== 1'b0 || bus.send_msg !== 32'h0 || bus.send_idx !== 2'd0 ||
        bus.send_last !== 1'b0 || bus.recv_rdy !== 1'b1 || bus.req_rdy !== 1'b0 ||
        dbg_state !== ST_LOAD) begin
      errors++;
      $display("FAIL reset: val=%b msg=%h idx=%0d last=%b recv_rdy=%b req_rdy=%b state=%0d, required 0/0/0/0/1/0/0",
               bus.send_val, bus.send_msg, bus.send_idx, bus.send_last,
               bus.recv_rdy, bus.req_rdy, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stage0();
    load_table(tbl_a);
    request(2'd0, 1'b0);
    collect("stage0_fwd", exp_s0, 1'b0);
  endtask

  task automatic test_stage1_priority();
    // request and sample together in IDLE: the request must win
    @(negedge clk);
    bus.req_stage   = 2'd1;
    bus.req_inverse = 1'b0;
    bus.req_val     = 1'b1;
    bus.recv_val    = 1'b1;
    bus.recv_msg    = 16'h7777;
    #1;
    checks++;
    if (bus.recv_rdy !== 1'b0 || bus.req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL priority: recv_rdy=%b req_rdy=%b, required 0/1", bus.recv_rdy, bus.req_rdy);
    end
    @(posedge clk);
    #1;
    bus.req_val  = 1'b0;
    bus.recv_val = 1'b0;
    checks++;
    if (bus.send_val !== 1'b1) begin
      errors++;
      $display("FAIL stage1_latency: send_val=%b, required 1", bus.send_val);
    end
    collect("stage1_fwd", exp_s1, 1'b0);
  endtask

  task automatic test_stage2();
    request(2'd2, 1'b0);
    collect("stage2_fwd", exp_s2, 1'b0);
    request(2'd2, 1'b1);
    collect("stage2_inv", exp_s2_inv, 1'b0);
  endtask

  task automatic test_backpressure();
    request(2'd2, 1'b0);
    collect("stage2_stall", exp_s2, 1'b1);
    request(2'd2, 1'b1);
    collect("stage2_inv_stall", exp_s2_inv, 1'b1);
  endtask

  task automatic test_saturate_clamp();
    load_table(tbl_b);
    request(2'd1, 1'b0);
    collect("saturate_s1", exp_b_s1, 1'b0);
    request(2'd2, 1'b0);
    collect("saturate_s2", exp_b_s2, 1'b0);
    request(2'd3, 1'b0);
    collect("clamp_s3", exp_b_s2, 1'b0);
  endtask

  task automatic test_reset_midstream();
    request(2'd2, 1'b0);
    @(negedge clk);
    bus.send_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.send_rdy = 1'b0;
    #1;
    checks++;
    if (bus.send_val !== 1'b1 || bus.send_idx !== 2'd1 || bus.send_msg !== 32'h00B5_FF4B) begin
      errors++;
      $display("FAIL mid_stream: val=%b idx=%0d msg=%h, required 1/1/00b5ff4b",
               bus.send_val, bus.send_idx, bus.send_msg);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.send_val !== 1'b0 || bus.req_rdy !== 1'b0 || bus.recv_rdy !== 1'b1 ||
        dbg_state !== ST_LOAD) begin
      errors++;
      $display("FAIL async_reset: val=%b req_rdy=%b recv_rdy=%b state=%0d, required 0/0/1/%0d",
               bus.send_val, bus.req_rdy, bus.recv_rdy, dbg_state, ST_LOAD);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.req_stage = 2'd0;
      bus.req_val   = 1'b1;
      #1;
      checks++;
      if (bus.req_rdy !== 1'b0 || dbg_state !== ST_LOAD) begin
        errors++;
        $display("FAIL refuse_req cycle %0d: req_rdy=%b state=%0d, required 0/%0d",
                 c, bus.req_rdy, dbg_state, ST_LOAD);
      end
    end
    @(negedge clk);
    bus.req_val = 1'b0;
    load_table(tbl_a);
    request(2'd0, 1'b0);
    collect("after_reload", exp_s0, 1'b0);
  endtask

  // -------------------------------------------------------------- main
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stage0();
    test_stage1_priority();
    test_stage2();
    test_backpressure();
    test_saturate_clamp();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
